blackjack_dealer_ctrl: RTL and testbench
========================================

# blackjack_dealer_ctrl

Game-sequencing controller for the card game. Owns the `draw_card` resource. Issues draw requests, routes each returned card to the player or dealer hand, and tracks both hand totals. Runs the player/dealer turn state machine and reports the round outcome to the display/score logic.

## Interface
- `DRAW_LAT`, default 1: clock cycles from the `draw` pulse until `card_in` is valid. Legal range 1–4.
- `DEALER_STAND`, default 17: the dealer stops drawing at a total ≥ this value.
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  pulse; begins a round. Honoured only in IDLE or DONE.
- `hit`  in  1  pulse; player requests a card. Honoured only in PLAY_WAIT.
- `stand`  in  1  pulse; player ends their turn. Honoured only in PLAY_WAIT.
- `card_in`  in  4  card rank from `draw_card`, encoded 1..13.
- `draw`  out  1  one-cycle pulse that triggers a `draw_card` sample.
- `player_total`  out  5  best total of the player hand.
- `dealer_total`  out  5  best total of the dealer hand.
- `player_turn`  out  1  high while in PLAY_WAIT.
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  high in DONE.
- `result`  out  2  round outcome: 00 none, 01 player win, 10 dealer win, 11 push.

## Operation
- States: IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, PLAY_WAIT, PLAY_HIT, DEALER_TURN, RESOLVE, DONE.
- Card fetch: every card-drawing state runs the same sequence.
  - Pulse `draw` for one cycle.
  - Wait `DRAW_LAT` cycles.
  - Sample `card_in` and add its value to the target hand.
- Card value: rank 1 is an ace (1); ranks 2–10 are face value; ranks 11–13 are 10.
- Invalid rank (0, 14 or 15): the card is discarded and `draw` is re-pulsed. The state does not change and the hand is not touched. There is no retry limit.
- Each hand keeps a hard total (aces counted as 1, 5 bits) and an `has_ace` flag. The best total is hard+10 when the soft-ace rule applies, otherwise hard.
- Maximum hard total is 31 (21 + 10), so 5 bits is sufficient with no overflow path.
- Deal order: IDLE/DONE → `start` → clear hands and `result`, then P1 → D1 → P2 → D2 → PLAY_WAIT.
- PLAY_WAIT transitions:
  - `stand` → DEALER_TURN. If `hit` and `stand` arrive together, `stand` wins.
  - `hit` → PLAY_HIT, fetch one card, then re-evaluate.
- Player re-evaluation, checked after D2 and after every PLAY_HIT card:
  - best total > 21 → RESOLVE, with no further dealer draws.
  - best total == 21 → DEALER_TURN (auto-stand).
  - otherwise → PLAY_WAIT.
- DEALER_TURN: while dealer best total < `DEALER_STAND`, fetch a card; otherwise go to RESOLVE.
- RESOLVE, evaluated in this order, lasts one cycle, then DONE:
  - player > 21 → 10.
  - dealer > 21 → 01.
  - player > dealer → 01.
  - player < dealer → 10.
  - equal → 11.
- DONE holds totals and `result` until `start` or `reset`.
- `hit`/`stand` outside PLAY_WAIT, and `start` while `busy`, are ignored with no side effects.

## Timing
- Reset values: state IDLE; `draw`, `player_turn`, `busy`, `done` = 0; both totals 0; `result` = 00; internal flags cleared.
- Reset has priority over every input in every state, including mid-fetch. The next cycle is IDLE with all outputs at reset values.
- `draw` is high in cycle t. `card_in` is sampled on the edge ending cycle t+`DRAW_LAT`. The updated total is visible in cycle t+`DRAW_LAT`+1.
- `start` to first `draw`: 1 cycle.
- `result` becomes valid in the same cycle `done` first rises.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `BJ_SOFT_ACE_EN`.
- Defined: the soft-ace rule applies, i.e. best total = hard+10 when `has_ace` and hard+10 ≤ 21. The dealer stands on soft totals ≥ `DEALER_STAND`.
- Undefined: aces always count 1; best total = hard. The `has_ace` logic is compiled out.

## Structure
- Package `blackjack_pkg` holds:
  - the state enum;
  - `result` encodings (RES_NONE, RES_PLAYER, RES_DEALER, RES_PUSH);
  - constants BUST_LIMIT = 21, FACE_VALUE = 10, ACE_BONUS = 10;
  - the rank-to-value function.
- Sub-module `hand_accumulator`, instantiated twice (player and dealer). It has clear/add/value ports and holds the hard total and `has_ace`, and outputs the best total.

## Test plan
- Dealer win: `start`; cards P=10, D=6, P=7, D=13 (player 17, dealer 16); `stand`; dealer card 5 → dealer 21, `result`=10, `done`=1.
- Player bust: deal P=10, D=9, P=5, D=8; `hit` with card 12 → player 25; RESOLVE with no further `draw` pulses; `result`=10.
- Soft ace (macro defined): deal P=1, D=10, P=13, D=7 → player 21 auto-stands; dealer 17 stands; `result`=01. With the macro undefined, the same cards give player 11 and PLAY_WAIT.
- Invalid cards: during DEAL_P1 feed 0, then 14, then 5 → three `draw` pulses; `player_total`=5; the state advances only after the 5.
- Push and input races: totals 19/19 → `result`=11. `hit`+`stand` in the same cycle → DEALER_TURN with no player draw. `start` while `busy` is ignored.
- Reset mid-DEALER_TURN, asserted during the fetch wait: next cycle IDLE, totals 0, `result`=00, `draw`=0. A subsequent `start` runs a clean round.

Source files
------------

// File: rtl/blackjack_dealer_ctrl_pkg.sv
// Shared definitions for the blackjack dealer controller.
//   - state_t      : turn-sequencing states
//   - RES_*        : encodings of the round outcome reported on `result`
//   - BUST_LIMIT, FACE_VALUE, ACE_BONUS : game constants
//   - rank_valid() : a rank from draw_card is usable (1..13)
//   - rank_value() : rank to hand value (ace = 1, faces = 10)
package blackjack_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEAL_P1,
    S_DEAL_D1,
    S_DEAL_P2,
    S_DEAL_D2,
    S_PLAY_WAIT,
    S_PLAY_HIT,
    S_DEALER_TURN,
    S_RESOLVE,
    S_DONE
  } state_t;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_PLAYER = 2'b01;
  localparam logic [1:0] RES_DEALER = 2'b10;
  localparam logic [1:0] RES_PUSH   = 2'b11;

  localparam logic [4:0] BUST_LIMIT = 5'd21;
  localparam logic [4:0] FACE_VALUE = 5'd10;
  localparam logic [4:0] ACE_BONUS  = 5'd10;

  function automatic logic rank_valid(input logic [3:0] rank);
    return (rank != 4'd0) && (rank <= 4'd13);
  endfunction

  // Ranks 10..13 are all worth ten; an invalid rank is never added, so its
  // value here does not matter.
  function automatic logic [4:0] rank_value(input logic [3:0] rank);
    if (rank >= 4'd10) return FACE_VALUE;
    return {1'b0, rank};
  endfunction

endpackage

// File: rtl/blackjack_dealer_ctrl_if.sv
// Handshake/bus bundle between the dealer controller and its environment.
//   start/hit/stand : one-cycle request pulses from the player/UI
//   card_in         : rank returned by draw_card (1..13)
//   draw            : one-cycle pulse asking draw_card for a new sample
//   player_total, dealer_total : best hand totals
//   player_turn, busy, done, result : round status for display/score logic
// Modport master is the controller, slave is the surrounding system.
interface blackjack_dealer_ctrl_if;

  logic       start;
  logic       hit;
  logic       stand;
  logic [3:0] card_in;
  logic       draw;
  logic [4:0] player_total;
  logic [4:0] dealer_total;
  logic       player_turn;
  logic       busy;
  logic       done;
  logic [1:0] result;

  modport master (
    input  start, hit, stand, card_in,
    output draw, player_total, dealer_total, player_turn, busy, done, result
  );

  modport slave (
    output start, hit, stand, card_in,
    input  draw, player_total, dealer_total, player_turn, busy, done, result
  );

endinterface

// File: rtl/blackjack_dealer_ctrl_hand_accumulator.sv
// hand_accumulator: running total for one blackjack hand.
//   clock, reset : system clock, synchronous active-high reset
//   clear        : empty the hand (start of a round)
//   add, value   : add one card of the given value (1..10)
//   best_total   : best total of the hand
// Macro BJ_SOFT_ACE_EN: when defined, one ace may count 11 (hard+10) as long
// as that does not exceed 21; when undefined the ace flag is not built and
// the best total is the hard total.
module hand_accumulator
  import blackjack_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       add,
  input  logic [4:0] value,
  output logic [4:0] best_total
);

  logic [4:0] hard_q, hard_d;

  // Hard total never exceeds 31 (a 21 hand plus a ten), so no overflow guard.
  always_comb begin
    hard_d = hard_q;
    if (clear)    hard_d = '0;
    else if (add) hard_d = hard_q + value;
  end

  always_ff @(posedge clock) begin
    if (reset) hard_q <= '0;
    else       hard_q <= hard_d;
  end

`ifdef BJ_SOFT_ACE_EN
  logic has_ace_q, has_ace_d;

  always_comb begin
    has_ace_d = has_ace_q;
    if (clear)                      has_ace_d = 1'b0;
    else if (add && value == 5'd1)  has_ace_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) has_ace_q <= 1'b0;
    else       has_ace_q <= has_ace_d;
  end

  // Compare against 21-10 rather than forming hard+10, which could wrap.
  assign best_total = (has_ace_q && hard_q <= (BUST_LIMIT - ACE_BONUS))
                      ? hard_q + ACE_BONUS : hard_q;
`else
  assign best_total = hard_q;
`endif

endmodule

// File: rtl/blackjack_dealer_ctrl.sv
// blackjack_dealer_ctrl: round sequencer for the blackjack game.
//   clock, reset : system clock, synchronous active-high reset
//   bus (master) : start/hit/stand requests, card_in from draw_card, draw
//                  pulse out, both best totals, player_turn/busy/done/result
// Parameters: DRAW_LAT (1..4) cycles from draw to a valid card_in;
//             DEALER_STAND total at which the dealer stops drawing.
// Macro BJ_SOFT_ACE_EN enables the soft-ace rule in both hands.
module blackjack_dealer_ctrl
  import blackjack_pkg::*;
#(
  parameter int DRAW_LAT     = 1,
  parameter int DEALER_STAND = 17
) (
  input logic                     clock,
  input logic                     reset,
  blackjack_dealer_ctrl_if.master bus
);

  localparam logic [2:0] LAT_CNT  = 3'(DRAW_LAT);
  localparam logic [4:0] STAND_AT = 5'(DEALER_STAND);

  state_t     state_q, state_d;
  logic       draw_q, draw_d;
  logic [2:0] cnt_q, cnt_d;      // fetch wait countdown, 1 = sample now
  logic       pend_q, pend_d;    // hit card added, re-evaluate next cycle
  logic [1:0] result_q, result_d;

  logic       p_clr, p_add, d_clr, d_add;
  logic [4:0] card_val, p_best, d_best;
  logic       sample, card_ok, fetching;

  function automatic state_t player_next(input logic [4:0] p);
    if (p > BUST_LIMIT)  return S_RESOLVE;
    if (p == BUST_LIMIT) return S_DEALER_TURN;
    return S_PLAY_WAIT;
  endfunction

  function automatic logic [1:0] resolve(input logic [4:0] p, input logic [4:0] d);
    if (p > BUST_LIMIT) return RES_DEALER;
    if (d > BUST_LIMIT) return RES_PLAYER;
    if (p > d)          return RES_PLAYER;
    if (p < d)          return RES_DEALER;
    return RES_PUSH;
  endfunction

  assign card_val = rank_value(bus.card_in);
  assign card_ok  = rank_valid(bus.card_in);
  assign sample   = (cnt_q == 3'd1);
  assign fetching = draw_q || (cnt_q != 3'd0);

  hand_accumulator u_player (
    .clock      (clock),
    .reset      (reset),
    .clear      (p_clr),
    .add        (p_add),
    .value      (card_val),
    .best_total (p_best)
  );

  hand_accumulator u_dealer (
    .clock      (clock),
    .reset      (reset),
    .clear      (d_clr),
    .add        (d_add),
    .value      (card_val),
    .best_total (d_best)
  );

  always_comb begin
    state_d  = state_q;
    draw_d   = 1'b0;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    result_d = result_q;
    p_clr    = 1'b0;
    p_add    = 1'b0;
    d_clr    = 1'b0;
    d_add    = 1'b0;

    // Every fetch: draw pulse, then DRAW_LAT wait cycles, card sampled in
    // the last one.
    if (draw_q)              cnt_d = LAT_CNT;
    else if (cnt_q != 3'd0)  cnt_d = cnt_q - 3'd1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          p_clr    = 1'b1;
          d_clr    = 1'b1;
          result_d = RES_NONE;
          pend_d   = 1'b0;
          draw_d   = 1'b1;
          state_d  = S_DEAL_P1;
        end
      end
      // A bad rank re-pulses draw in place; a good one moves on and
      // immediately starts the next deal fetch.
      S_DEAL_P1, S_DEAL_P2: begin
        if (sample) begin
          draw_d = 1'b1;
          if (card_ok) begin
            p_add   = 1'b1;
            state_d = (state_q == S_DEAL_P1) ? S_DEAL_D1 : S_DEAL_D2;
          end
        end
      end
      S_DEAL_D1: begin
        if (sample) begin
          draw_d = 1'b1;
          if (card_ok) begin
            d_add   = 1'b1;
            state_d = S_DEAL_P2;
          end
        end
      end
      // Player hand is already complete here, so it can be judged directly.
      S_DEAL_D2: begin
        if (sample) begin
          if (card_ok) begin
            d_add   = 1'b1;
            state_d = player_next(p_best);
          end else begin
            draw_d = 1'b1;
          end
        end
      end
      S_PLAY_WAIT: begin
        if (bus.stand) begin
          state_d = S_DEALER_TURN;
        end else if (bus.hit) begin
          draw_d  = 1'b1;
          state_d = S_PLAY_HIT;
        end
      end
      // The new card shows in p_best one cycle after it is added.
      S_PLAY_HIT: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          state_d = player_next(p_best);
        end else if (sample) begin
          if (card_ok) begin
            p_add  = 1'b1;
            pend_d = 1'b1;
          end else begin
            draw_d = 1'b1;
          end
        end
      end
      // Between fetches the dealer total is current; decide draw or stand.
      S_DEALER_TURN: begin
        if (!fetching) begin
          if (d_best < STAND_AT) draw_d  = 1'b1;
          else                   state_d = S_RESOLVE;
        end else if (sample) begin
          if (card_ok) d_add  = 1'b1;
          else         draw_d = 1'b1;
        end
      end
      S_RESOLVE: begin
        result_d = resolve(p_best, d_best);
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      draw_q   <= 1'b0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      result_q <= RES_NONE;
    end else begin
      state_q  <= state_d;
      draw_q   <= draw_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      result_q <= result_d;
    end
  end

  assign bus.draw         = draw_q;
  assign bus.player_total = p_best;
  assign bus.dealer_total = d_best;
  assign bus.player_turn  = (state_q == S_PLAY_WAIT);
  assign bus.busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.result       = result_q;

endmodule

// File: tb/tb_blackjack_dealer_ctrl.sv
// Bench for blackjack_dealer_ctrl: directed rounds, a card-level game model
// checked every cycle, and literal expectations at key points of each round.
module tb_blackjack_dealer_ctrl;

  localparam int LAT   = 2;
  localparam int STAND = 17;
`ifdef BJ_SOFT_ACE_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  blackjack_dealer_ctrl_if bus();

  blackjack_dealer_ctrl #(.DRAW_LAT(LAT), .DEALER_STAND(STAND)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Card supply: next deck card is presented whenever draw pulses.
  logic [3:0] deck [0:255];
  int deck_wr = 0;
  int deck_rd = 0;

  initial begin
    bus.card_in = 4'd0;
    forever begin
      @(negedge clock);
      if (bus.draw === 1'b1) begin
        bus.card_in = deck[deck_rd];
        deck_rd++;
      end
    end
  end

  // ---------------- game model ----------------
  int ncyc = 0;
  int m_ph = 0, m_dh = 0, m_ncards = 0, m_cnt = 0;
  bit m_pa = 0, m_da = 0, m_started = 0, m_stood = 0;
  int m_pbest = 0, m_dbest = 0, m_res = 0;
  bit m_dphase = 0, m_complete = 0;

  function automatic int best_of(input int hard, input bit ace);
    if (SOFT && ace && hard + 10 <= 21) return hard + 10;
    return hard;
  endfunction

  function automatic int outcome(input int p, input int d);
    if (p > 21) return 2;
    if (d > 21) return 1;
    if (p > d)  return 1;
    if (p < d)  return 2;
    return 3;
  endfunction

  initial begin
    forever begin
      @(posedge clock);
      ncyc++;
      if (reset) begin
        m_ph = 0; m_dh = 0; m_pa = 0; m_da = 0;
        m_ncards = 0; m_cnt = 0; m_started = 0; m_stood = 0;
      end else begin
        bit stand_ok;
        stand_ok = bus.stand && m_started && m_ncards >= 4 && !m_dphase &&
                   m_pbest < 21 && m_cnt == 0 && !bus.draw;
        if (m_cnt == 1 && bus.card_in >= 1 && bus.card_in <= 13) begin
          int v;
          v = (bus.card_in > 10) ? 10 : int'(bus.card_in);
          if (m_ncards < 4 ? (m_ncards % 2 == 0) : !m_dphase) begin
            m_ph += v; if (v == 1) m_pa = 1;
          end else begin
            m_dh += v; if (v == 1) m_da = 1;
          end
          m_ncards++;
        end
        if (bus.draw) m_cnt = LAT;
        else if (m_cnt > 0) m_cnt--;
        if (stand_ok) m_stood = 1;
        if (bus.start && (!m_started || m_complete)) begin
          m_ph = 0; m_dh = 0; m_pa = 0; m_da = 0;
          m_ncards = 0; m_cnt = 0; m_stood = 0; m_started = 1;
        end
      end
      m_pbest    = best_of(m_ph, m_pa);
      m_dbest    = best_of(m_dh, m_da);
      m_dphase   = m_started && m_ncards >= 4 && (m_stood || m_pbest == 21);
      m_complete = m_started && m_ncards >= 4 &&
                   (m_pbest > 21 || (m_dphase && m_dbest >= STAND));
      m_res      = outcome(m_pbest, m_dbest);
    end
  end

  // ---------------- compare ----------------
  int n_checks = 0, n_fails = 0, draw_total = 0;
  string lit_name = "";
  int lit_p, lit_d, lit_res, lit_done, lit_turn, lit_busy, lit_draws, lit_drawnow, lit_evt;
  int lit_req = 0, lit_ack = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (ncyc > 0) begin
        if (bus.draw) draw_total++;
        chk("player_total", int'(bus.player_total), m_pbest);
        chk("dealer_total", int'(bus.dealer_total), m_dbest);
        chk("result", int'(bus.result), bus.done ? m_res : 0);
        chk("done before round complete", int'(bus.done && !m_complete), 0);
        chk("draw outside live round", int'(bus.draw && !(m_started && !m_complete)), 0);
        chk("busy", int'(bus.busy), int'(m_started && !bus.done));
        chk("player_turn outside player phase",
            int'(bus.player_turn && !(m_started && m_ncards >= 4 && !m_dphase)), 0);
        if (lit_req != lit_ack) begin
          if (lit_evt >= 0)     chk({lit_name, " reached"}, lit_evt, 1);
          if (lit_p >= 0)       chk({lit_name, " player_total"}, int'(bus.player_total), lit_p);
          if (lit_d >= 0)       chk({lit_name, " dealer_total"}, int'(bus.dealer_total), lit_d);
          if (lit_res >= 0)     chk({lit_name, " result"}, int'(bus.result), lit_res);
          if (lit_done >= 0)    chk({lit_name, " done"}, int'(bus.done), lit_done);
          if (lit_turn >= 0)    chk({lit_name, " player_turn"}, int'(bus.player_turn), lit_turn);
          if (lit_busy >= 0)    chk({lit_name, " busy"}, int'(bus.busy), lit_busy);
          if (lit_draws >= 0)   chk({lit_name, " draw count"}, draw_total, lit_draws);
          if (lit_drawnow >= 0) chk({lit_name, " draw"}, int'(bus.draw), lit_drawnow);
          lit_ack = lit_req;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic lit(input string nm, input int p, input int d, input int res,
                     input int dn, input int turn, input int busy,
                     input int draws, input int drawnow);
    @(posedge clock); #1;
    lit_name = nm; lit_p = p; lit_d = d; lit_res = res; lit_done = dn;
    lit_turn = turn; lit_busy = busy; lit_draws = draws; lit_drawnow = drawnow;
    lit_evt = -1;
    lit_req++;
    @(negedge clock);
  endtask

  task automatic req_evt(input string nm, input int ok);
    @(posedge clock); #1;
    lit_name = nm; lit_p = -1; lit_d = -1; lit_res = -1; lit_done = -1;
    lit_turn = -1; lit_busy = -1; lit_draws = -1; lit_drawnow = -1;
    lit_evt = ok;
    lit_req++;
    @(negedge clock);
  endtask

  // kind 0: done, 1: player_turn, 2: next draw pulse
  task automatic wait_for(input int kind, input string nm);
    int ok;
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      if ((kind == 0 && bus.done) || (kind == 1 && bus.player_turn) ||
          (kind == 2 && bus.draw)) begin
        ok = 1;
        break;
      end
    end
    req_evt(nm, ok);
  endtask

  task automatic push(input int c);
    deck[deck_wr] = 4'(c);
    deck_wr++;
  endtask

  task automatic push4(input int a, input int b, input int c, input int d);
    push(a); push(b); push(c); push(d);
  endtask

  task automatic snap(output int b);
    @(posedge clock); #1;
    b = draw_total;
    @(negedge clock);
  endtask

  task automatic pulse(input int which);
    if (which == 0) bus.start = 1'b1;
    if (which == 1) bus.hit   = 1'b1;
    if (which == 2) bus.stand = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    bus.hit   = 1'b0;
    bus.stand = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.start = 1'b0;
    bus.hit   = 1'b0;
    bus.stand = 1'b0;
    reset     = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    lit("reset", 0, 0, 0, 0, 0, 0, -1, 0);

    // Dealer win: player 17, dealer 16 draws a 5.
    push4(10, 6, 7, 13); push(5);
    snap(base);
    pulse(0);
    wait_for(1, "t1 play_wait");
    lit("t1 deal", 17, 16, 0, 0, 1, 1, base + 4, -1);
    pulse(2);
    wait_for(0, "t1 done");
    lit("t1 end", 17, 21, 2, 1, 0, 0, base + 5, 0);

    // Player bust on a hit: no dealer draw afterwards.
    push4(10, 9, 5, 8); push(12);
    snap(base);
    pulse(0);
    wait_for(1, "t2 play_wait");
    pulse(1);
    wait_for(0, "t2 done");
    lit("t2 end", 25, 17, 2, 1, 0, 0, base + 5, 0);

    // Ace + king.
    push4(1, 10, 13, 7);
    snap(base);
    pulse(0);
`ifdef BJ_SOFT_ACE_EN
    wait_for(0, "t3 done");
    lit("t3 soft end", 21, 17, 1, 1, 0, 0, base + 4, 0);
`else
    wait_for(1, "t3 play_wait");
    lit("t3 hard deal", 11, 17, 0, 0, 1, 1, base + 4, -1);
    pulse(2);
    wait_for(0, "t3 done");
    lit("t3 hard end", 11, 17, 2, 1, 0, 0, base + 4, 0);
`endif

    // Invalid ranks during the first player card.
    push4(0, 14, 5, 10); push(8); push(9);
    snap(base);
    pulse(0);
    repeat (3) wait_for(2, "t4 draw");
    lit("t4 after P1", 5, 0, 0, 0, 0, 1, base + 4, -1);
    wait_for(1, "t4 play_wait");
    lit("t4 deal", 13, 19, 0, 0, 1, 1, base + 6, -1);
    pulse(2);
    wait_for(0, "t4 done");
    lit("t4 end", 13, 19, 2, 1, 0, 0, base + 6, 0);

    // Push, start while busy, hit+stand together.
    push4(10, 10, 9, 9);
    snap(base);
    pulse(0);
    @(negedge clock);
    pulse(0);
    wait_for(1, "t5 play_wait");
    lit("t5 deal", 19, 19, 0, 0, 1, 1, base + 4, -1);
    bus.hit   = 1'b1;
    bus.stand = 1'b1;
    @(negedge clock);
    bus.hit   = 1'b0;
    bus.stand = 1'b0;
    wait_for(0, "t5 done");
    lit("t5 end", 19, 19, 3, 1, 0, 0, base + 4, 0);

    // Reset while the dealer's card fetch is waiting, then a clean round.
    push4(10, 6, 7, 13); push(4);
    pulse(0);
    wait_for(1, "t6 play_wait");
    pulse(2);
    wait_for(2, "t6 dealer draw");
    reset = 1'b1;
    lit("t6 reset", 0, 0, 0, 0, 0, 0, -1, 0);
    reset = 1'b0;
    push4(10, 6, 7, 13); push(5);
    snap(base);
    pulse(0);
    wait_for(1, "t6 play_wait 2");
    pulse(2);
    wait_for(0, "t6 done");
    lit("t6 end", 17, 21, 2, 1, 0, 0, base + 5, 0);

    @(posedge clock); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
